// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key expansion block.
//   AES_NR     : number of AES-128 rounds (round keys 0..AES_NR are produced)
//   RCON_INIT  : round constant for the first expansion step
//   state_t    : key-expansion FSM encoding
//   key_t      : 128-bit key viewed as four 32-bit words, w0 in the MSBs
//   xtime      : multiply by x in GF(2^8), reduced by 8'h1B
//   rot_word   : AES RotWord, rotate a word left by one byte
package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RDY,
        ST_SUB,
        ST_XOR
    } state_t;

    // Packed struct: the first member lands in the MSBs, so w0 is byte 0..3.
    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [31:0] w3;
    } key_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox_rom.sv
// AES forward S-box as an 8->8 ROM with a registered output (one-cycle read).
//   clk  : clock
//   en   : read enable; data holds its last value while low
//   addr : input byte
//   data : S-box(addr), valid the cycle after addr/en are presented
module aes_sbox_rom (
    input  logic       clk,
    input  logic       en,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // NOTE: the ROM read register has no reset; a resettable output would stop
    // the table and register from mapping onto a block RAM, and the consumer
    // only samples data one cycle after a qualified read.
    always_ff @(posedge clk) begin
        if (en) begin
            data <= SBOX[addr];
        end
    end

endmodule

// File: rtl/aes_128_key_expand.sv
// On-the-fly AES-128 round-key generator. A master key is latched on key_load;
// each accepted key_ready emits the next round key (0..NR) one cycle later.
// The following key is computed in the three-cycle gap after each emission:
// ST_SUB reads the S-box, ST_XOR folds the result into the staged key.
//   clk       : clock
//   kill      : synchronous active-high reset
//   key_load  : one-cycle strobe, latch key_in as the master key
//   key_in    : cipher key, byte 0 in [127:120]
//   key_ready : request for the next round key
//   round_key : last emitted round key (held between requests)
//   rk_valid  : one-cycle pulse when round_key is updated
//   rk_idx    : index of round_key (0..NR)
//   key_err   : sticky, a request arrived with no key staged; cleared by kill
module aes_128_key_expand
    import aes_pkg::*;
#(
    parameter int NR       = AES_NR,
    parameter int SBOX_LAT = 1      // only a one-cycle S-box is supported
) (
    input  logic         clk,
    input  logic         kill,
    input  logic         key_load,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic         rk_valid,
    output logic [3:0]   rk_idx,
    output logic         key_err
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    // The ST_SUB -> ST_XOR schedule assumes the ROM answers in one cycle.
    if (SBOX_LAT != 1) begin : g_sbox_lat_unsupported
    end

    state_t       state;
    state_t       state_next;
    logic [127:0] master;
    logic [127:0] staged;
    logic [7:0]   rcon;
    logic [3:0]   next_idx;

    // Request decode and next state.
    logic         emit;
    logic         err_pulse;
    logic         wrap;
    logic [127:0] emit_key;
    logic [3:0]   emit_idx;

    // NOTE: every output of this block is given a default before any branch so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        emit       = 1'b0;
        err_pulse  = 1'b0;
        wrap       = 1'b0;
        emit_key   = staged;
        emit_idx   = next_idx;

        // A load in the same cycle as a request emits the new key as round 0.
        if (key_load) begin
            emit_key = key_in;
            emit_idx = '0;
        end

        if (key_ready) begin
            if (key_load || state == ST_RDY) begin
                emit = 1'b1;
            end else begin
                err_pulse = 1'b1;
            end
        end

        if (emit) begin
            wrap       = (emit_idx == LAST_IDX);
            state_next = wrap ? ST_RDY : ST_SUB;
        end else if (key_load) begin
            state_next = ST_RDY;
        end else begin
            case (state)
                ST_SUB:  state_next = ST_XOR;
                ST_XOR:  state_next = ST_RDY;
                default: state_next = state;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (kill) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-key datapath, always derived from the key currently on round_key.
    key_t        cur;
    key_t        nxt;
    logic [31:0] rot_w3;
    logic [31:0] sub_word;
    logic [31:0] t_word;
    logic        sbox_en;

    assign cur     = key_t'(round_key);
    assign rot_w3  = rot_word(cur.w3);
    assign sbox_en = (state == ST_SUB);

    // Byte lanes of RotWord map straight through to SubWord.
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox_rom u_sbox (
            .clk  (clk),
            .en   (sbox_en),
            .addr (rot_w3[8*i +: 8]),
            .data (sub_word[8*i +: 8])
        );
    end

    assign t_word = sub_word ^ {rcon, 24'h0};
    assign nxt.w0 = cur.w0 ^ t_word;
    assign nxt.w1 = cur.w1 ^ nxt.w0;
    assign nxt.w2 = cur.w2 ^ nxt.w1;
    assign nxt.w3 = cur.w3 ^ nxt.w2;

    always_ff @(posedge clk) begin
        if (kill) begin
            round_key <= '0;
            rk_valid  <= 1'b0;
            rk_idx    <= '0;
            key_err   <= 1'b0;
            master    <= '0;
            staged    <= '0;
            rcon      <= RCON_INIT;
            next_idx  <= '0;
        end else begin
            rk_valid <= emit;

            if (err_pulse) begin
                key_err <= 1'b1;
            end

            if (emit) begin
                round_key <= emit_key;
                rk_idx    <= emit_idx;
            end

            if (key_load) begin
                master   <= key_in;
                staged   <= key_in;
                rcon     <= RCON_INIT;
                next_idx <= '0;
            end

            // Later assignments override the plain-load defaults above.
            if (emit) begin
                if (wrap) begin
                    // Last round of the block: rewind for the next block.
                    staged   <= master;
                    rcon     <= RCON_INIT;
                    next_idx <= '0;
                end else begin
                    next_idx <= emit_idx + 4'd1;
                end
            end else if (!key_load && state == ST_XOR) begin
                staged <= nxt;
                rcon   <= xtime(rcon);
            end
        end
    end

endmodule

// File: tb/tb_aes_128_key_expand.sv
// Self-checking bench for aes_128_key_expand. Expected round keys come from an
// independent software key schedule whose S-box is derived from GF(2^8)
// inversion plus the affine map; emitted keys are queued at request time and
// compared when rk_valid is observed.
module tb_aes_128_key_expand;

    logic         clk = 1'b0;
    logic         kill;
    logic         key_load;
    logic [127:0] key_in;
    logic         key_ready;
    logic [127:0] round_key;
    logic         rk_valid;
    logic [3:0]   rk_idx;
    logic         key_err;

    always #5 clk = ~clk;

    aes_128_key_expand dut (
        .clk       (clk),
        .kill      (kill),
        .key_load  (key_load),
        .key_in    (key_in),
        .key_ready (key_ready),
        .round_key (round_key),
        .rk_valid  (rk_valid),
        .rk_idx    (rk_idx),
        .key_err   (key_err)
    );

    localparam logic [127:0] K1       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_IDX1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_IDX10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2       = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_IDX10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [7:0]   RCON_TAB [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                               8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t         sb[$];
    logic [7:0]   sbox_model [256];
    logic [127:0] exp_rk [11];
    int           model_next;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            end
            sbox_model[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_model[temp[31:24]], sbox_model[temp[23:16]],
                        sbox_model[temp[15:8]],  sbox_model[temp[7:0]]};
                temp = temp ^ {RCON_TAB[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r < 11; r++) begin
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        model_next = 0;
    endtask

    task automatic push_expected();
        exp_t e;
        e.idx = 4'(model_next);
        e.key = exp_rk[model_next];
        sb.push_back(e);
        model_next = (model_next == 10) ? 0 : model_next + 1;
    endtask

    // One-cycle request; the next request may follow 'gap' cycles later.
    task automatic send_ready(input bit accepted, input int gap);
        key_ready = 1'b1;
        if (accepted) push_expected();
        @(posedge clk); #1;
        key_ready = 1'b0;
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        build_model(k);
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    // Output monitor: every rk_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rk_valid === 1'b1) begin
            valid_cnt++;
            check("sb_has_entry", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rk_idx", 128'(rk_idx), 128'(e.idx));
                check("round_key", round_key, e.key);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int c0;
        kill      = 1'b1;
        key_load  = 1'b0;
        key_in    = '0;
        key_ready = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("rst_round_key", round_key, 128'd0);
        check("rst_rk_valid", 128'(rk_valid), 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        check("rst_key_err", 128'(key_err), 128'd0);
        kill = 1'b0;
        @(posedge clk); #1;

        // Request with no key ever loaded: no emission, error flag set.
        c0 = valid_cnt;
        send_ready(1'b0, 3);
        check("noload_key_err", 128'(key_err), 128'd1);
        check("noload_no_valid", 128'(valid_cnt - c0), 128'd0);
        kill = 1'b1;
        @(posedge clk); #1;
        check("kill_clears_err", 128'(key_err), 128'd0);
        kill = 1'b0;

        // Full block at the tightest request spacing.
        load_key(K1);
        c0 = valid_cnt;
        for (int r = 0; r <= 10; r++) begin
            send_ready(1'b1, 3);
            if (r == 0)  check("k1_idx0", round_key, K1);
            if (r == 1)  check("k1_idx1", round_key, K1_IDX1);
            if (r == 10) check("k1_idx10", round_key, K1_IDX10);
        end
        check("k1_pulse_count", 128'(valid_cnt - c0), 128'd11);
        check("k1_rk_idx_hold", 128'(rk_idx), 128'd10);

        // Second block without reloading repeats the same keys.
        c0 = valid_cnt;
        for (int r = 0; r <= 10; r++) begin
            send_ready(1'b1, 3);
            if (r == 0) check("blk2_idx0", round_key, K1);
        end
        check("blk2_pulse_count", 128'(valid_cnt - c0), 128'd11);
        check("blk2_no_err", 128'(key_err), 128'd0);

        // Request two cycles after an emission is rejected and flagged.
        send_ready(1'b1, 2);
        send_ready(1'b0, 1);
        check("early_key_err", 128'(key_err), 128'd1);
        check("early_idx_hold", 128'(rk_idx), 128'd0);
        send_ready(1'b1, 3);
        check("after_early_idx1", round_key, K1_IDX1);
        check("err_sticky", 128'(key_err), 128'd1);

        // Load and request together: the new key is round 0 next cycle.
        key_in    = K2;
        key_load  = 1'b1;
        key_ready = 1'b1;
        build_model(K2);
        push_expected();
        @(posedge clk); #1;
        key_load  = 1'b0;
        key_ready = 1'b0;
        check("k2_idx0_same_cycle", round_key, K2);
        repeat (2) begin
            @(posedge clk); #1;
        end
        for (int r = 1; r <= 10; r++) begin
            send_ready(1'b1, 3);
        end
        check("k2_idx10", round_key, K2_IDX10);
        check("k2_err_still_set", 128'(key_err), 128'd1);

        // Kill in the middle of a block, then restart from a fresh load.
        load_key(K1);
        for (int r = 0; r <= 3; r++) send_ready(1'b1, 3);
        send_ready(1'b1, 1);
        kill = 1'b1;
        @(posedge clk); #1;
        check("kill_round_key", round_key, 128'd0);
        check("kill_rk_idx", 128'(rk_idx), 128'd0);
        check("kill_rk_valid", 128'(rk_valid), 128'd0);
        check("kill_key_err", 128'(key_err), 128'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        load_key(K1);
        for (int r = 0; r <= 2; r++) begin
            send_ready(1'b1, 3);
            if (r == 0) check("restart_idx0", round_key, K1);
        end
        check("restart_rk_idx", 128'(rk_idx), 128'd2);
        check("restart_no_err", 128'(key_err), 128'd0);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
